risac_ifetch: RTL and testbench

RISAC_IFETCH -- requirements
Module: risac_ifetch

---
 rtl/risac_ifetch.sv | 179 +++++++++++++++++
 tb/tb_risac_ifetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/risac_ifetch.sv
// risac_ifetch: prefetch unit with a DEPTH-entry FIFO and redirect support.
// Optional perf counters are enabled by defining RISAC_IFETCH_PERF_EN.
module risac_ifetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] oIbusAddr,
  output logic              oIbusRead,
  input  logic              iIbusWait,
  input  logic [31:0]       iIbusData,
  input  logic              iRedirect,
  input  logic [ADDR_W-1:0] iRedirectPc,
  output logic              oValid,
  input  logic              iReady,
  output logic [31:0]       oInstr,
`ifdef RISAC_IFETCH_PERF_EN
  output logic [31:0]       oBubbleCnt,
  output logic [31:0]       oFetchCnt,
`endif
  output logic [ADDR_W-1:0] oPc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [ADDR_W-1:0]   r_redir_pc;
  logic [ADDR_W-1:0]   w_redir_nxt;

  logic                r_inflight;
  logic                r_inf_disc;
  logic [ADDR_W-1:0]   r_inf_addr;

  logic [31:0]         r_mem_instr [DEPTH];
  logic [ADDR_W-1:0]   r_mem_pc    [DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_room0;
  logic                w_room1;

  assign oIbusRead = (r_state != S_IDLE);
  assign oIbusAddr = r_pc;
  assign oValid    = (r_count != '0);
  assign oInstr    = r_mem_instr[r_rptr];
  assign oPc       = r_mem_pc[r_rptr];

  // Redirect wins over both FIFO ports in the same cycle.
  assign w_accept  = oIbusRead && !iIbusWait;
  assign w_push    = r_inflight && !r_inf_disc && !iRedirect;
  assign w_pop     = oValid && iReady && !iRedirect;

  assign w_cnt_nxt = iRedirect ? '0 :
                     r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_room0   = w_cnt_nxt < CNT_W'(DEPTH);
  assign w_room1   = (w_cnt_nxt + CNT_W'(1)) < CNT_W'(DEPTH);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_redir_nxt = r_redir_pc;
    unique case (r_state)
      S_IDLE: begin
        if (iRedirect)
          w_pc_nxt = iRedirectPc;
        if (w_room0)
          w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (w_accept) begin
          w_pc_nxt = iRedirect ? iRedirectPc
                               : r_pc + ADDR_W'(4);
          if (!w_room1)
            w_state_nxt = S_IDLE;
        end else if (iRedirect) begin
          w_redir_nxt = iRedirectPc;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (iRedirect)
          w_redir_nxt = iRedirectPc;
        if (w_accept) begin
          w_pc_nxt    = w_redir_nxt;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_redir_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_inf_disc <= 1'b0;
      r_inf_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_redir_pc <= w_redir_nxt;
      r_inflight <= w_accept;
      // A response accepted under a redirect belongs to the old stream.
      r_inf_disc <= iRedirect || (r_state == S_HOLD);
      r_inf_addr <= r_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_cnt_nxt;
      if (iRedirect) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push)
          r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop)
          r_rptr <= r_rptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= '0;
      end
    end else if (w_push) begin
      r_mem_instr[r_wptr] <= iIbusData;
      r_mem_pc[r_wptr]    <= r_inf_addr;
    end
  end

`ifdef RISAC_IFETCH_PERF_EN
  logic [31:0] r_bubble;
  logic [31:0] r_fetch;

  assign oBubbleCnt = r_bubble;
  assign oFetchCnt  = r_fetch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble <= '0;
      r_fetch  <= '0;
    end else begin
      if (iReady && !oValid && (r_bubble != '1))
        r_bubble <= r_bubble + 32'd1;
      if (w_pop)
        r_fetch <= r_fetch + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_risac_ifetch.sv
// tb_risac_ifetch: directed checks of the risac_ifetch prefetch unit.
// Memory model returns the request address as the instruction word.
module tb_risac_ifetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] oIbusAddr;
  logic        oIbusRead;
  logic        iIbusWait;
  logic [31:0] iIbusData;
  logic        iRedirect;
  logic [31:0] iRedirectPc;
  logic        oValid;
  logic        iReady;
  logic [31:0] oInstr;
  logic [31:0] oPc;
`ifdef RISAC_IFETCH_PERF_EN
  logic [31:0] oBubbleCnt;
  logic [31:0] oFetchCnt;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int n_acc    = 0;

  risac_ifetch #(
    .ADDR_W   (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .oIbusAddr   (oIbusAddr),
    .oIbusRead   (oIbusRead),
    .iIbusWait   (iIbusWait),
    .iIbusData   (iIbusData),
    .iRedirect   (iRedirect),
    .iRedirectPc (iRedirectPc),
    .oValid      (oValid),
    .iReady      (iReady),
    .oInstr      (oInstr),
`ifdef RISAC_IFETCH_PERF_EN
    .oBubbleCnt  (oBubbleCnt),
    .oFetchCnt   (oFetchCnt),
`endif
    .oPc         (oPc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = oIbusRead && !iIbusWait;
    a   = oIbusAddr;
    @(posedge clk);
    #1;
    if (acc) begin
      n_acc++;
      iIbusData = a;
    end else begin
      iIbusData = 32'hDEAD_BEEF;
    end
  endtask

  task automatic hold_reset();
    rst_n     = 1'b0;
    iRedirect = 1'b0;
    iIbusWait = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    iIbusWait   = 1'b0;
    iIbusData   = 32'h0;
    iRedirect   = 1'b0;
    iRedirectPc = 32'h0;
    iReady      = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'b0, oValid}, 32'd0);
    chk("rst_read", {31'b0, oIbusRead}, 32'd0);
    chk("rst_addr", oIbusAddr, 32'h0);
    chk("rst_instr", oInstr, 32'h0);
    chk("rst_pc", oPc, 32'h0);

    // streaming with no wait states
    iReady = 1'b1;
    rst_n  = 1'b1;
    chk("s_rd0", {31'b0, oIbusRead}, 32'd0);
    tick();
    chk("s_rd1", {31'b0, oIbusRead}, 32'd1);
    chk("s_addr0", oIbusAddr, 32'h0);
    tick();
    chk("s_nv", {31'b0, oValid}, 32'd0);
    chk("s_addr4", oIbusAddr, 32'h4);
    tick();
    chk("s_v", {31'b0, oValid}, 32'd1);
    chk("s_pc0", oPc, 32'h0);
    chk("s_in0", oInstr, 32'h0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("s_pc", oPc, 32'(4 * k));
      chk("s_in", oInstr, 32'(4 * k));
      chk("s_vk", {31'b0, oValid}, 32'd1);
    end

    // asynchronous reset in the middle of a request, then back-pressure
    iReady = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("ar_rd", {31'b0, oIbusRead}, 32'd0);
    chk("ar_v", {31'b0, oValid}, 32'd0);
    chk("ar_addr", oIbusAddr, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    n_acc = 0;
    chk("bp_rd0", {31'b0, oIbusRead}, 32'd0);
    tick();
    chk("bp_rd1", {31'b0, oIbusRead}, 32'd1);
    chk("bp_a0", oIbusAddr, 32'h0);
    repeat (10) tick();
    chk("bp_nacc", 32'(n_acc), 32'd4);
    chk("bp_rd", {31'b0, oIbusRead}, 32'd0);
    chk("bp_in", oInstr, 32'h0);
    chk("bp_pc", oPc, 32'h0);
    chk("bp_v", {31'b0, oValid}, 32'd1);
    iReady = 1'b1;
    tick();
    chk("bp_rd2", {31'b0, oIbusRead}, 32'd1);
    chk("bp_a10", oIbusAddr, 32'h10);
    chk("bp_pc4", oPc, 32'h4);
    tick();
    chk("bp_pc8", oPc, 32'h8);
    tick();
    chk("bp_pcc", oPc, 32'hC);
    tick();
    chk("bp_pc10", oPc, 32'h10);
    chk("bp_in10", oInstr, 32'h10);

    // redirect with 3 entries queued and 1 in flight
    iReady = 1'b0;
    hold_reset();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("rf_rd", {31'b0, oIbusRead}, 32'd0);
    chk("rf_v", {31'b0, oValid}, 32'd1);
    iRedirect   = 1'b1;
    iRedirectPc = 32'h100;
    tick();
    iRedirect = 1'b0;
    chk("rf_nv", {31'b0, oValid}, 32'd0);
    chk("rf_rd1", {31'b0, oIbusRead}, 32'd1);
    chk("rf_a", oIbusAddr, 32'h100);
    iReady = 1'b1;
    tick();
    chk("rf_nv2", {31'b0, oValid}, 32'd0);
    tick();
    chk("rf_v2", {31'b0, oValid}, 32'd1);
    chk("rf_pc", oPc, 32'h100);
    chk("rf_in", oInstr, 32'h100);

    // redirect while a request is held by wait
    hold_reset();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("hw_a8", oIbusAddr, 32'h8);
    iIbusWait = 1'b1;
    tick();
    chk("hw_a8b", oIbusAddr, 32'h8);
    chk("hw_rd", {31'b0, oIbusRead}, 32'd1);
    iRedirect   = 1'b1;
    iRedirectPc = 32'h40;
    tick();
    iRedirect = 1'b0;
    chk("hw_a8c", oIbusAddr, 32'h8);
    tick();
    chk("hw_a8d", oIbusAddr, 32'h8);
    iIbusWait = 1'b0;
    tick();
    chk("hw_a40", oIbusAddr, 32'h40);
    chk("hw_rd2", {31'b0, oIbusRead}, 32'd1);
    tick();
    chk("hw_nv", {31'b0, oValid}, 32'd0);
    tick();
    chk("hw_v", {31'b0, oValid}, 32'd1);
    chk("hw_pc", oPc, 32'h40);
    chk("hw_in", oInstr, 32'h40);

    // back-to-back redirects: the last one wins
    iRedirect   = 1'b1;
    iRedirectPc = 32'h200;
    tick();
    iRedirectPc = 32'h300;
    tick();
    iRedirect = 1'b0;
    chk("lr_a", oIbusAddr, 32'h300);
    chk("lr_nv", {31'b0, oValid}, 32'd0);
    tick();
    chk("lr_nv2", {31'b0, oValid}, 32'd0);
    tick();
    chk("lr_v", {31'b0, oValid}, 32'd1);
    chk("lr_pc", oPc, 32'h300);

    // address wrap at the top of the space
    iRedirect   = 1'b1;
    iRedirectPc = 32'hFFFF_FFFC;
    tick();
    iRedirect = 1'b0;
    chk("wr_atop", oIbusAddr, 32'hFFFF_FFFC);
    tick();
    chk("wr_a0", oIbusAddr, 32'h0);
    tick();
    chk("wr_pctop", oPc, 32'hFFFF_FFFC);
    tick();
    chk("wr_pc0", oPc, 32'h0);
    chk("wr_in0", oInstr, 32'h0);

`ifdef RISAC_IFETCH_PERF_EN
    hold_reset();
    chk("pf_b0", oBubbleCnt, 32'd0);
    chk("pf_f0", oFetchCnt, 32'd0);
    iReady    = 1'b1;
    iIbusWait = 1'b1;
    rst_n     = 1'b1;
    tick();
    repeat (5) tick();
    iIbusWait = 1'b0;
    tick();
    tick();
    chk("pf_b8", oBubbleCnt, 32'd8);
    chk("pf_fz", oFetchCnt, 32'd0);
    chk("pf_v", {31'b0, oValid}, 32'd1);
    tick();
    tick();
    chk("pf_f2", oFetchCnt, 32'd2);
    chk("pf_b8b", oBubbleCnt, 32'd8);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
